// File: rtl/johnson_phase_tracker.sv
// johnson_phase_tracker
// Decodes a Johnson-coded phase from an upstream counter, classifies each
// sample as hold / forward step / bad step against the previous legal
// sample, and runs a lock FSM (UNLOCKED -> ACQUIRE -> LOCKED) on top of it.
// All outputs are registered; one cycle from an in_valid sample to the
// decoded outputs.
// Optional feature: define JPT_REV_COUNT_EN to count completed revolutions
// while locked on rev_count; without it rev_count is tied to zero.
module johnson_phase_tracker #(
    parameter int WIDTH      = 4,
    parameter int LOCK_STEPS = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              in_code,
    input  logic                          in_valid,
    input  logic                          clr_err,
    output logic [$clog2(2*WIDTH)-1:0]    phase,
    output logic [2*WIDTH-1:0]            phase_onehot,
    output logic                          code_legal,
    output logic                          locked,
    output logic                          step_err,
    output logic                          err_sticky,
    output logic [7:0]                    rev_count
);

    localparam int NPH = 2 * WIDTH;
    localparam int PW  = $clog2(NPH);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t        state;
    logic [3:0]    step_cnt;

    logic          dec_legal;
    logic [PW-1:0] dec_phase;
    logic [PW-1:0] fwd_phase;
    logic          is_fwd;
    logic          is_hold;
    logic          is_bad;
    logic [3:0]    cnt_nxt;

    // Legal code for phase k: k<=WIDTH ones from bit 0, otherwise
    // (2*WIDTH-k) ones packed against the MSB.
    function automatic logic [WIDTH-1:0] jcode(input int k);
        logic [WIDTH-1:0] c;
        c = '0;
        for (int b = 0; b < WIDTH; b++) begin
            if (k <= WIDTH) c[b] = (b < k);
            else            c[b] = (b >= WIDTH - (NPH - k));
        end
        return c;
    endfunction

    // Decode the incoming code and classify it against the last legal phase.
    // The phase register always holds the last legal phase, so it doubles
    // as the step reference.
    always_comb begin
        dec_legal = 1'b0;
        dec_phase = '0;
        for (int k = 0; k < NPH; k++) begin
            if (in_code == jcode(k)) begin
                dec_legal = 1'b1;
                dec_phase = PW'(k);
            end
        end
        fwd_phase = (phase == PW'(NPH - 1)) ? '0 : phase + PW'(1);
        is_fwd    = dec_legal && (dec_phase == fwd_phase);
        is_hold   = dec_legal && (dec_phase == phase);
        is_bad    = !(is_fwd || is_hold);
        cnt_nxt   = step_cnt + 4'd1;
    end

    // Lock FSM with registered decode outputs and error flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= UNLOCKED;
            step_cnt     <= 4'd0;
            phase        <= '0;
            phase_onehot <= '0;
            code_legal   <= 1'b0;
            locked       <= 1'b0;
            step_err     <= 1'b0;
            err_sticky   <= 1'b0;
        end else begin
            step_err <= 1'b0;
            if (clr_err) err_sticky <= 1'b0;
            if (in_valid) begin
                code_legal   <= dec_legal;
                phase_onehot <= dec_legal ? ({{(NPH-1){1'b0}}, 1'b1} << dec_phase) : '0;
                if (dec_legal) phase <= dec_phase;
                case (state)
                    UNLOCKED: begin
                        if (dec_legal) begin
                            state    <= ACQUIRE;
                            step_cnt <= 4'd0;
                        end
                    end
                    ACQUIRE: begin
                        if (is_bad) begin
                            state      <= UNLOCKED;
                            step_cnt   <= 4'd0;
                            step_err   <= 1'b1;
                            err_sticky <= 1'b1;
                        end else if (is_fwd) begin
                            step_cnt <= cnt_nxt;
                            if (cnt_nxt == 4'(LOCK_STEPS)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (is_bad) begin
                            state      <= UNLOCKED;
                            step_cnt   <= 4'd0;
                            locked     <= 1'b0;
                            step_err   <= 1'b1;
                            err_sticky <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= UNLOCKED;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef JPT_REV_COUNT_EN
    logic [7:0] rev_q;

    // Count wraps from the last phase back to 0 while locked.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rev_q <= 8'd0;
        end else if (in_valid && state == LOCKED && is_fwd && phase == PW'(NPH - 1)) begin
            rev_q <= rev_q + 8'd1;
        end
    end

    assign rev_count = rev_q;
`else
    assign rev_count = 8'd0;
`endif

endmodule
